triangle_dispatch: RTL and testbench
====================================

# triangle_dispatch

Frame-level triangle buffer and sequencer that sits directly upstream of the `triangle_color` rasterizer. It collects screen-space vertices from the projection stage three at a time, clamps them to the screen and stores each triangle with its colour. At end of frame it issues the stored triangles one at a time to the rasterizer, waiting for the rasterizer's `last_out` before issuing the next one.

## Interface
- `MAX_TRIANGLES`, 72: storage depth in triangles (6 objects × 12).
- `WIDTH`, 1024: screen width; x is clamped to `WIDTH-1`.
- `HEIGHT`, 720: screen height; y is clamped to `HEIGHT-1`.
- `clk_in`  in  1  single system clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `vertex_valid_in`  in  1  vertex beat valid; accepted only when `ready_out`=1.
- `vertex_in`  in  20  {x[19:10], y[9:0]}, unsigned screen coordinates.
- `color_in`  in  24  triangle RGB, sampled with the third vertex of a triangle.
- `frame_last_in`  in  1  end of triangle list for this frame; accepted only when `ready_out`=1.
- `raster_last_in`  in  1  rasterizer `last_out`: current triangle finished.
- `ready_out`  out  1  high in COLLECT only.
- `tri_valid_out`  out  1  single-cycle pulse; drives rasterizer `valid_in`.
- `vertex_a_out`, `vertex_b_out`, `vertex_c_out`  out  20 each  triangle vertices in {x,y} format.
- `color_out`  out  24  colour of the triangle currently issued.
- `frame_done_out`  out  1  single-cycle pulse: all triangles of the frame have been rasterized.
- `overflow_out`  out  1  sticky: at least one triangle of the current frame was dropped.

## Operation
- States: COLLECT, FETCH, ISSUE, WAIT.
- COLLECT:
  - Each accepted vertex goes into slot `vcnt` (0=a, 1=b, 2=c), after clamping x to min(x, WIDTH-1) and y to min(y, HEIGHT-1).
  - On `vcnt`=2: write {a, b, c, color_in} to entry `tri_cnt`, increment `tri_cnt`, and set `vcnt`=0.
  - If `tri_cnt`=MAX_TRIANGLES, the completed triangle is discarded and `overflow_out` is set.
- `frame_last_in` in COLLECT:
  - If a vertex is also accepted in the same cycle, the vertex is processed first (a completing third vertex is stored and counted).
  - A partial triangle (`vcnt`≠0 after that) is discarded and `vcnt` is cleared.
  - If the resulting count is 0: pulse `frame_done_out` and stay in COLLECT.
  - Otherwise: set `rd_idx`=0 and go to FETCH.
- FETCH: registered read of entry `rd_idx` (one cycle); go to ISSUE.
- ISSUE:
  - Load the vertex and colour outputs from the read data and assert `tri_valid_out` for exactly this cycle.
  - Go to WAIT. Outputs hold stable until the next ISSUE.
- WAIT: on `raster_last_in`:
  - If `rd_idx`=`tri_cnt`-1: pulse `frame_done_out`, clear `tri_cnt`, and go to COLLECT.
  - Else: increment `rd_idx` and go to FETCH.
- Ignored inputs:
  - `raster_last_in` outside WAIT is ignored.
  - `vertex_valid_in` and `frame_last_in` outside COLLECT are ignored; upstream holds them until `ready_out` is high.
- `overflow_out` clears on the first vertex accepted after `frame_done_out`.
- Widths: `tri_cnt` is $clog2(MAX_TRIANGLES+1) bits; `rd_idx` is $clog2(MAX_TRIANGLES) bits. Clamp comparisons are 10-bit unsigned.

## Timing
- Reset values:
  - All outputs 0, except `ready_out`=1.
  - State COLLECT; `vcnt`, `tri_cnt`, `rd_idx` all 0.
  - Storage contents are don't-care.
- Reset mid-frame or mid-raster aborts everything; no `frame_done_out` is produced.
- Throughput: one vertex per cycle in COLLECT.
- `frame_last_in` accepted at cycle N with a non-empty list: FETCH at N+1, `tri_valid_out` at N+2.
- `raster_last_in` at cycle M, not the last triangle: next `tri_valid_out` at M+2.
- `raster_last_in` at cycle M, last triangle: `frame_done_out`=1 and `ready_out`=1 at M+1.
- Empty frame: `frame_done_out` at N+1; `ready_out` never drops.

## Test plan
- **Single triangle.** Stimulus: vertices (10,10), (20,10), (10,20) with colour 0xFF0000, then `frame_last_in`. Response: one `tri_valid_out` pulse 2 cycles later with a=0x0280A, b=0x0500A, c=0x02814; `raster_last_in` → `frame_done_out` 1 cycle later.
- **Clamp.** Stimulus: vertex x=1023, y=900. Response: stored and issued as y=719; x=1023 is unchanged.
- **Simultaneous third vertex and `frame_last_in`.** Response: the triangle is counted and issued.
- **Partial triangle.** Stimulus: 4 vertices then `frame_last_in`. Response: exactly one triangle is issued.
- **Overflow.** Stimulus: 73 triangles. Response: `overflow_out`=1; 72 issues in write order; `overflow_out` clears on the next frame's first vertex.
- **Reset and empty frame.**
  - Assert `rst_in` while in WAIT. Response: next cycle `ready_out`=1, `tri_valid_out`=0, and a later empty frame gives `frame_done_out` 1 cycle after `frame_last_in`.
  - Stray `raster_last_in` in COLLECT has no effect.

Source files
------------

// File: rtl/triangle_dispatch.sv
// -----------------------------------------------------------------------------
// triangle_dispatch
//
// Frame-level triangle buffer and sequencer feeding the triangle_color
// rasterizer. Collects clamped screen-space vertices three at a time, stores
// each completed triangle with its colour, and at end of frame replays the
// stored triangles one at a time, waiting for the rasterizer's last_out
// between triangles.
//
// Ports
//   clk_in           system clock
//   rst_in           synchronous, active-high reset
//   vertex_valid_in  vertex beat valid (taken only while ready_out=1)
//   vertex_in        {x[19:10], y[9:0]} unsigned screen coordinates
//   color_in         triangle RGB, sampled with the third vertex
//   frame_last_in    end of this frame's triangle list (taken while ready_out=1)
//   raster_last_in   rasterizer last_out: current triangle finished
//   ready_out        high while collecting vertices
//   tri_valid_out    one-cycle pulse to rasterizer valid_in
//   vertex_a/b/c_out issued triangle vertices, {x,y}
//   color_out        issued triangle colour
//   frame_done_out   one-cycle pulse: whole frame rasterized
//   overflow_out     sticky: a triangle of the current frame was dropped
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accept vertices / frame_last, build and store triangles
// FETCH   | registered read of entry rd_idx into the output registers
// ISSUE   | tri_valid_out pulse with the fetched triangle on the outputs
// WAIT    | hold outputs until raster_last_in, then next triangle or done
// -----------------------------------------------------------------------------
module triangle_dispatch #(
    parameter int MAX_TRIANGLES = 72,
    parameter int WIDTH         = 1024,
    parameter int HEIGHT        = 720
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        vertex_valid_in,
    input  logic [19:0] vertex_in,
    input  logic [23:0] color_in,
    input  logic        frame_last_in,
    input  logic        raster_last_in,
    output logic        ready_out,
    output logic        tri_valid_out,
    output logic [19:0] vertex_a_out,
    output logic [19:0] vertex_b_out,
    output logic [19:0] vertex_c_out,
    output logic [23:0] color_out,
    output logic        frame_done_out,
    output logic        overflow_out
);

    localparam int TC_W  = $clog2(MAX_TRIANGLES + 1);
    localparam int RI_W  = $clog2(MAX_TRIANGLES);
    localparam int ENT_W = 3 * 20 + 24;

    localparam logic [9:0]      X_MAX   = 10'(WIDTH - 1);
    localparam logic [9:0]      Y_MAX   = 10'(HEIGHT - 1);
    localparam logic [TC_W-1:0] TC_FULL = TC_W'(MAX_TRIANGLES);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FETCH   = 2'd1,
        S_ISSUE   = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]       vcnt;
    logic [TC_W-1:0]  tri_cnt;
    logic [TC_W-1:0]  tri_last;
    logic [RI_W-1:0]  rd_idx;
    logic [19:0]      vtx_a;
    logic [19:0]      vtx_b;
    logic [ENT_W-1:0] tri_mem [MAX_TRIANGLES];

    logic [9:0]  x_raw;
    logic [9:0]  y_raw;
    logic [9:0]  x_clamp;
    logic [9:0]  y_clamp;
    logic [19:0] vtx_clamped;

    logic vtx_acc;
    logic frm_acc;
    logic tri_complete;
    logic tri_store;
    logic tri_drop;
    logic frame_done_next;
    logic frame_end;
    logic rd_adv;

    // Written as min() with "<" so the compare stays meaningful even when
    // the limit is the full 10-bit range.
    assign x_raw       = vertex_in[19:10];
    assign y_raw       = vertex_in[9:0];
    assign x_clamp     = (x_raw < X_MAX) ? x_raw : X_MAX;
    assign y_clamp     = (y_raw < Y_MAX) ? y_raw : Y_MAX;
    assign vtx_clamped = {x_clamp, y_clamp};

    assign tri_last = tri_cnt - 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        ready_out       = 1'b0;
        tri_valid_out   = 1'b0;
        vtx_acc         = 1'b0;
        frm_acc         = 1'b0;
        tri_complete    = 1'b0;
        tri_store       = 1'b0;
        tri_drop        = 1'b0;
        frame_done_next = 1'b0;
        frame_end       = 1'b0;
        rd_adv          = 1'b0;

        case (state)
            S_COLLECT: begin
                ready_out    = 1'b1;
                vtx_acc      = vertex_valid_in;
                frm_acc      = frame_last_in;
                tri_complete = vtx_acc && (vcnt == 2'd2);
                tri_store    = tri_complete && (tri_cnt != TC_FULL);
                tri_drop     = tri_complete && (tri_cnt == TC_FULL);
                if (frm_acc) begin
                    // A triangle completed in this same cycle counts.
                    if ((tri_cnt == '0) && !tri_store) begin
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                tri_valid_out = 1'b1;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (raster_last_in) begin
                    if (TC_W'(rd_idx) == tri_last) begin
                        frame_done_next = 1'b1;
                        frame_end       = 1'b1;
                        state_next      = S_COLLECT;
                    end else begin
                        rd_adv     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_COLLECT;
            end
        endcase
    end

    // Triangle storage; contents are don't-care after reset.
    always_ff @(posedge clk_in) begin
        if (tri_store) begin
            tri_mem[tri_cnt[RI_W-1:0]] <= {vtx_a, vtx_b, vtx_clamped, color_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vcnt           <= 2'd0;
            tri_cnt        <= '0;
            rd_idx         <= '0;
            vtx_a          <= '0;
            vtx_b          <= '0;
            overflow_out   <= 1'b0;
            frame_done_out <= 1'b0;
            vertex_a_out   <= '0;
            vertex_b_out   <= '0;
            vertex_c_out   <= '0;
            color_out      <= '0;
        end else begin
            frame_done_out <= frame_done_next;

            if (vtx_acc) begin
                case (vcnt)
                    2'd0: begin
                        vtx_a <= vtx_clamped;
                        vcnt  <= 2'd1;
                    end
                    2'd1: begin
                        vtx_b <= vtx_clamped;
                        vcnt  <= 2'd2;
                    end
                    default: begin
                        vcnt <= 2'd0;
                    end
                endcase
            end
            // frame_last drops any partial triangle, including one started
            // by a vertex in this same cycle.
            if (frm_acc) begin
                vcnt <= 2'd0;
            end

            if (tri_store) begin
                tri_cnt <= tri_cnt + 1'b1;
            end else if (frame_end) begin
                tri_cnt <= '0;
            end

            if (frm_acc) begin
                rd_idx <= '0;
            end else if (rd_adv) begin
                rd_idx <= rd_idx + 1'b1;
            end

            // The first vertex of a new frame is the only accepted vertex
            // with both counters at zero.
            if (tri_drop) begin
                overflow_out <= 1'b1;
            end else if (vtx_acc && (vcnt == 2'd0) && (tri_cnt == '0)) begin
                overflow_out <= 1'b0;
            end

            if (state == S_FETCH) begin
                {vertex_a_out, vertex_b_out, vertex_c_out, color_out} <= tri_mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_triangle_dispatch.sv
// -----------------------------------------------------------------------------
// Directed testbench for triangle_dispatch. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_triangle_dispatch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        vertex_valid_in;
    logic [19:0] vertex_in;
    logic [23:0] color_in;
    logic        frame_last_in;
    logic        raster_last_in;
    logic        ready_out;
    logic        tri_valid_out;
    logic [19:0] vertex_a_out;
    logic [19:0] vertex_b_out;
    logic [19:0] vertex_c_out;
    logic [23:0] color_out;
    logic        frame_done_out;
    logic        overflow_out;

    int n_checks = 0;
    int n_fail   = 0;

    triangle_dispatch #(
        .MAX_TRIANGLES(72),
        .WIDTH        (1024),
        .HEIGHT       (720)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .vertex_valid_in(vertex_valid_in),
        .vertex_in      (vertex_in),
        .color_in       (color_in),
        .frame_last_in  (frame_last_in),
        .raster_last_in (raster_last_in),
        .ready_out      (ready_out),
        .tri_valid_out  (tri_valid_out),
        .vertex_a_out   (vertex_a_out),
        .vertex_b_out   (vertex_b_out),
        .vertex_c_out   (vertex_c_out),
        .color_out      (color_out),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_vtx(input logic [9:0] x, input logic [9:0] y,
                            input logic [23:0] col, input logic last);
        vertex_valid_in = 1'b1;
        vertex_in       = {x, y};
        color_in        = col;
        frame_last_in   = last;
        tick();
        vertex_valid_in = 1'b0;
        frame_last_in   = 1'b0;
    endtask

    task automatic send_last();
        frame_last_in = 1'b1;
        tick();
        frame_last_in = 1'b0;
    endtask

    task automatic raster_pulse();
        raster_last_in = 1'b1;
        tick();
        raster_last_in = 1'b0;
    endtask

    // Leaves the bench in the ISSUE cycle when seen=1.
    task automatic wait_issue(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (tri_valid_out === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick(); tick();
        rst_in = 1'b0;
        tick();
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_tri_valid: got %b expected 0", tri_valid_out); end
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done_out); end
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
        n_checks++; if ({vertex_a_out, vertex_b_out, vertex_c_out, color_out} !== 84'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {vertex_a_out, vertex_b_out, vertex_c_out, color_out}); end
    endtask

    task automatic test_single();
        send_vtx(10'd10, 10'd10, 24'hFF0000, 1'b0);
        send_vtx(10'd20, 10'd10, 24'hFF0000, 1'b0);
        send_vtx(10'd10, 10'd20, 24'hFF0000, 1'b0);
        send_last();
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_fetch_valid: got %b expected 0", tri_valid_out); end
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL single_fetch_ready: got %b expected 0", ready_out); end
        tick();
        n_checks++; if (tri_valid_out !== 1'b1) begin n_fail++; $display("FAIL single_issue_latency: got %b expected 1", tri_valid_out); end
        n_checks++; if (vertex_a_out !== 20'h0280A) begin n_fail++; $display("FAIL single_a: got %h expected 0280a", vertex_a_out); end
        n_checks++; if (vertex_b_out !== 20'h0500A) begin n_fail++; $display("FAIL single_b: got %h expected 0500a", vertex_b_out); end
        n_checks++; if (vertex_c_out !== 20'h02814) begin n_fail++; $display("FAIL single_c: got %h expected 02814", vertex_c_out); end
        n_checks++; if (color_out !== 24'hFF0000) begin n_fail++; $display("FAIL single_color: got %h expected ff0000", color_out); end
        tick();
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", tri_valid_out); end
        n_checks++; if (vertex_a_out !== 20'h0280A) begin n_fail++; $display("FAIL single_hold: got %h expected 0280a", vertex_a_out); end
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL single_frame_done: got %b expected 1", frame_done_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b expected 1", ready_out); end
        tick();
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", frame_done_out); end
    endtask

    task automatic test_clamp();
        bit seen;
        send_vtx(10'd1023, 10'd900, 24'h123456, 1'b0);
        send_vtx(10'd1023, 10'd719, 24'h123456, 1'b0);
        send_vtx(10'd0,    10'd720, 24'h123456, 1'b0);
        send_last();
        wait_issue(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL clamp_issue: got no tri_valid_out expected pulse"); end
        n_checks++; if (vertex_a_out !== {10'd1023, 10'd719}) begin n_fail++; $display("FAIL clamp_a: got %h expected %h", vertex_a_out, {10'd1023, 10'd719}); end
        n_checks++; if (vertex_b_out !== {10'd1023, 10'd719}) begin n_fail++; $display("FAIL clamp_b: got %h expected %h", vertex_b_out, {10'd1023, 10'd719}); end
        n_checks++; if (vertex_c_out !== {10'd0, 10'd719}) begin n_fail++; $display("FAIL clamp_c: got %h expected %h", vertex_c_out, {10'd0, 10'd719}); end
        tick();
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL clamp_done: got %b expected 1", frame_done_out); end
    endtask

    task automatic test_simultaneous();
        send_vtx(10'd1, 10'd2, 24'h000000, 1'b0);
        send_vtx(10'd3, 10'd4, 24'h000000, 1'b0);
        send_vtx(10'd5, 10'd6, 24'hABCDEF, 1'b1);
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL simul_fetch: got ready %b expected 0", ready_out); end
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL simul_no_empty_done: got %b expected 0", frame_done_out); end
        tick();
        n_checks++; if (tri_valid_out !== 1'b1) begin n_fail++; $display("FAIL simul_issue: got %b expected 1", tri_valid_out); end
        n_checks++; if (vertex_c_out !== {10'd5, 10'd6}) begin n_fail++; $display("FAIL simul_c: got %h expected %h", vertex_c_out, {10'd5, 10'd6}); end
        n_checks++; if (color_out !== 24'hABCDEF) begin n_fail++; $display("FAIL simul_color: got %h expected abcdef", color_out); end
        tick();
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL simul_done: got %b expected 1", frame_done_out); end
    endtask

    task automatic test_partial();
        bit seen;
        int extra;
        send_vtx(10'd7,  10'd8,  24'h00FF00, 1'b0);
        send_vtx(10'd9,  10'd10, 24'h00FF00, 1'b0);
        send_vtx(10'd11, 10'd12, 24'h00FF00, 1'b0);
        send_vtx(10'd13, 10'd14, 24'h0000FF, 1'b0);
        send_last();
        wait_issue(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL partial_issue: got no tri_valid_out expected pulse"); end
        n_checks++; if (vertex_a_out !== {10'd7, 10'd8}) begin n_fail++; $display("FAIL partial_a: got %h expected %h", vertex_a_out, {10'd7, 10'd8}); end
        n_checks++; if (color_out !== 24'h00FF00) begin n_fail++; $display("FAIL partial_color: got %h expected 00ff00", color_out); end
        tick();
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL partial_done: got %b expected 1", frame_done_out); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tri_valid_out === 1'b1) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL partial_extra_issue: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        send_vtx(10'd100, 10'd200, 24'h000001, 1'b0);
        send_vtx(10'd300, 10'd400, 24'h000001, 1'b0);
        send_vtx(10'd500, 10'd600, 24'h000001, 1'b0);
        send_vtx(10'd600, 10'd700, 24'h000002, 1'b0);
        send_vtx(10'd800, 10'd10,  24'h000002, 1'b0);
        send_vtx(10'd1000, 10'd20, 24'h000002, 1'b0);
        send_last();
        wait_issue(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_first_issue: got no tri_valid_out expected pulse"); end
        n_checks++; if (vertex_b_out !== {10'd300, 10'd400}) begin n_fail++; $display("FAIL b2b_first_b: got %h expected %h", vertex_b_out, {10'd300, 10'd400}); end
        // raster_last during ISSUE must be ignored
        raster_pulse();
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_ignore_issue_1: got %b expected 0", tri_valid_out); end
        tick();
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_ignore_issue_2: got %b expected 0", tri_valid_out); end
        raster_pulse();
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_m_plus_1: got %b expected 0", tri_valid_out); end
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done: got %b expected 0", frame_done_out); end
        tick();
        n_checks++; if (tri_valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_m_plus_2: got %b expected 1", tri_valid_out); end
        n_checks++; if (vertex_a_out !== {10'd600, 10'd700}) begin n_fail++; $display("FAIL b2b_second_a: got %h expected %h", vertex_a_out, {10'd600, 10'd700}); end
        n_checks++; if (vertex_c_out !== {10'd1000, 10'd20}) begin n_fail++; $display("FAIL b2b_second_c: got %h expected %h", vertex_c_out, {10'd1000, 10'd20}); end
        n_checks++; if (color_out !== 24'h000002) begin n_fail++; $display("FAIL b2b_second_color: got %h expected 000002", color_out); end
        tick();
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", frame_done_out); end
    endtask

    task automatic test_overflow();
        bit          seen;
        logic [9:0]  t10;
        logic [23:0] col;
        for (int t = 0; t < 73; t++) begin
            t10 = 10'(t);
            col = {16'h00C0, t10[7:0]};
            send_vtx(t10, t10 + 10'd1, col, 1'b0);
            send_vtx(t10 + 10'd2, 10'd3, col, 1'b0);
            send_vtx(10'd4, t10, col, 1'b0);
            if (t == 71) begin
                n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", overflow_out); end
            end
        end
        n_checks++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_out); end
        send_last();
        for (int k = 0; k < 72; k++) begin
            wait_issue(seen);
            n_checks++;
            if (!seen) begin
                n_fail++; $display("FAIL ovf_issue_timeout: got no pulse expected issue %0d", k);
                break;
            end
            t10 = 10'(k);
            col = {16'h00C0, t10[7:0]};
            if (vertex_a_out !== {t10, t10 + 10'd1} || color_out !== col) begin
                n_fail++; $display("FAIL ovf_order_%0d: got a=%h col=%h expected a=%h col=%h", k, vertex_a_out, color_out, {t10, t10 + 10'd1}, col);
            end
            tick();
            raster_pulse();
        end
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b expected 1", frame_done_out); end
        n_checks++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_out); end
        tick();
        send_vtx(10'd0, 10'd0, 24'h0, 1'b0);
        n_checks++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow_out); end
        send_last();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL ovf_partial_empty_done: got %b expected 1", frame_done_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL ovf_partial_empty_ready: got %b expected 1", ready_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        send_vtx(10'd50, 10'd60,  24'h777777, 1'b0);
        send_vtx(10'd70, 10'd80,  24'h777777, 1'b0);
        send_vtx(10'd90, 10'd100, 24'h777777, 1'b0);
        send_last();
        wait_issue(seen);
        tick();
        rst_in = 1'b1;
        tick();
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", ready_out); end
        n_checks++; if (tri_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", tri_valid_out); end
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", frame_done_out); end
        rst_in = 1'b0;
        tick();
        raster_pulse();
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL stray_raster_ready: got %b expected 1", ready_out); end
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL stray_raster_done: got %b expected 0", frame_done_out); end
        send_last();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b expected 1", frame_done_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL empty_ready: got %b expected 1", ready_out); end
        tick();
        n_checks++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse: got %b expected 0", frame_done_out); end
        send_vtx(10'd2, 10'd3, 24'h010203, 1'b0);
        send_vtx(10'd4, 10'd5, 24'h010203, 1'b0);
        send_vtx(10'd6, 10'd7, 24'h010203, 1'b0);
        send_last();
        wait_issue(seen);
        n_checks++; if (vertex_a_out !== {10'd2, 10'd3}) begin n_fail++; $display("FAIL post_rst_a: got %h expected %h", vertex_a_out, {10'd2, 10'd3}); end
        tick();
        raster_pulse();
        n_checks++; if (frame_done_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_single_done: got %b expected 1", frame_done_out); end
    endtask

    initial begin
        rst_in          = 1'b1;
        vertex_valid_in = 1'b0;
        vertex_in       = '0;
        color_in        = '0;
        frame_last_in   = 1'b0;
        raster_last_in  = 1'b0;
        test_reset();
        test_single();
        test_clamp();
        test_simultaneous();
        test_partial();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
